rtc_read_sequencer: RTL and testbench

- Generates one complete read cycle on the RTC's multiplexed address/data bus (Intel style, active-low CS/RD/WR/A_D) and captures the byte returned by the RTC.
- It is the read-side counterpart of the write-path bus multiplexer: it drives the address phase, releases the bus, then samples the RTC data.
- The top level uses ad_oe to decide who drives the shared AD lines. The controller FSM issues requests through start/addr and consumes rd_data on done.

---
 rtl/rtc_read_sequencer.sv | 143 ++++++++++++++
 tb/tb_rtc_read_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rtc_read_sequencer.sv
// RTC multiplexed-bus read sequencer: address phase, turnaround, data capture.
// Optional bcd_err output enabled by defining RTC_READ_BCD_CHECK_EN.
module rtc_read_sequencer #(
  parameter int T_PHASE = 2,
  parameter int DW      = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] addr,
  input  logic [DW-1:0] ad_in,
  output logic [DW-1:0] ad_out,
  output logic          ad_oe,
  output logic          cs_n,
  output logic          rd_n,
  output logic          wr_n,
  output logic          a_d_n,
  output logic          busy,
  output logic [DW-1:0] rd_data,
`ifdef RTC_READ_BCD_CHECK_EN
  output logic          bcd_err,
`endif
  output logic          done
);

  localparam int CW = $clog2(T_PHASE + 1);
  localparam logic [CW-1:0] LOAD = CW'(T_PHASE - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR_SETUP,
    ADDR_STROBE,
    ADDR_HOLD,
    TURN,
    DATA_RD,
    DATA_HOLD,
    DONE
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          last;
  logic [DW-1:0] cap;

  logic cs_n_d, rd_n_d, wr_n_d, a_d_n_d;
  logic ad_oe_d, busy_d, done_d;
  logic in_addr_d;

  assign last = (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Outputs are decoded from the next state so they are glitch-free flops.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      IDLE:        if (start) state_d = ADDR_SETUP;
      ADDR_SETUP:  if (last)  state_d = ADDR_STROBE;
      ADDR_STROBE: if (last)  state_d = ADDR_HOLD;
      ADDR_HOLD:   if (last)  state_d = TURN;
      TURN:        if (last)  state_d = DATA_RD;
      DATA_RD:     if (last)  state_d = DATA_HOLD;
      DATA_HOLD:   if (last)  state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase

    if (state_d != state) cnt_d = LOAD;
    else if (!last)       cnt_d = cnt - CW'(1);

    in_addr_d = (state_d == ADDR_SETUP) ||
                (state_d == ADDR_STROBE) ||
                (state_d == ADDR_HOLD);
    ad_oe_d = in_addr_d;
    a_d_n_d = !in_addr_d;
    cs_n_d  = !(in_addr_d || state_d == DATA_RD);
    wr_n_d  = (state_d != ADDR_STROBE);
    rd_n_d  = (state_d != DATA_RD);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_n  <= 1'b1;
      rd_n  <= 1'b1;
      wr_n  <= 1'b1;
      a_d_n <= 1'b1;
      ad_oe <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      cs_n  <= cs_n_d;
      rd_n  <= rd_n_d;
      wr_n  <= wr_n_d;
      a_d_n <= a_d_n_d;
      ad_oe <= ad_oe_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ad_out <= '0;
      cap    <= '0;
    end else begin
      if (state == IDLE && start)
        ad_out <= addr;
      if (state == DATA_RD && last)
        cap <= ad_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (state_d == DONE) begin
      rd_data <= cap;
    end
  end

`ifdef RTC_READ_BCD_CHECK_EN
  // Nibble check assumes the low byte of the bus carries the BCD value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_err <= 1'b0;
    end else if (state_d == DONE) begin
      bcd_err <= (cap[7:4] > 4'd9) || (cap[3:0] > 4'd9);
    end
  end
`endif

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Directed scoreboard bench for rtc_read_sequencer (T_PHASE=2 and T_PHASE=1).
module tb_rtc_read_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       sel;
  logic [7:0] addr;
  logic [7:0] rtc_val;

  logic       start0, start1;
  logic [7:0] ad_in0, ad_in1;
  logic [7:0] ad_out0, ad_out1, rd_data0, rd_data1;
  logic       ad_oe0, cs_n0, rd_n0, wr_n0, a_d_n0, busy0, done0;
  logic       ad_oe1, cs_n1, rd_n1, wr_n1, a_d_n1, busy1, done1;
`ifdef RTC_READ_BCD_CHECK_EN
  logic       bcd_err0, bcd_err1, o_bcd_err;
`endif

  logic [7:0] o_ad_out, o_rd_data;
  logic       o_ad_oe, o_cs_n, o_rd_n, o_wr_n, o_a_d_n, o_busy, o_done;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  assign start0 = start && !sel;
  assign start1 = start && sel;
  assign ad_in0 = rd_n0 ? 8'h00 : rtc_val;
  assign ad_in1 = rd_n1 ? 8'h00 : rtc_val;

  rtc_read_sequencer #(.T_PHASE(2), .DW(8)) dut (
    .clk(clk), .reset(reset), .start(start0), .addr(addr),
    .ad_in(ad_in0), .ad_out(ad_out0), .ad_oe(ad_oe0),
    .cs_n(cs_n0), .rd_n(rd_n0), .wr_n(wr_n0), .a_d_n(a_d_n0),
    .busy(busy0), .rd_data(rd_data0),
`ifdef RTC_READ_BCD_CHECK_EN
    .bcd_err(bcd_err0),
`endif
    .done(done0)
  );

  rtc_read_sequencer #(.T_PHASE(1), .DW(8)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .addr(addr),
    .ad_in(ad_in1), .ad_out(ad_out1), .ad_oe(ad_oe1),
    .cs_n(cs_n1), .rd_n(rd_n1), .wr_n(wr_n1), .a_d_n(a_d_n1),
    .busy(busy1), .rd_data(rd_data1),
`ifdef RTC_READ_BCD_CHECK_EN
    .bcd_err(bcd_err1),
`endif
    .done(done1)
  );

  always_comb begin
    o_ad_out  = sel ? ad_out1  : ad_out0;
    o_rd_data = sel ? rd_data1 : rd_data0;
    o_ad_oe   = sel ? ad_oe1   : ad_oe0;
    o_cs_n    = sel ? cs_n1    : cs_n0;
    o_rd_n    = sel ? rd_n1    : rd_n0;
    o_wr_n    = sel ? wr_n1    : wr_n0;
    o_a_d_n   = sel ? a_d_n1   : a_d_n0;
    o_busy    = sel ? busy1    : busy0;
    o_done    = sel ? done1    : done0;
`ifdef RTC_READ_BCD_CHECK_EN
    o_bcd_err = sel ? bcd_err1 : bcd_err0;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cs_n"},   o_cs_n,    1);
    chk({tag, "_rd_n"},   o_rd_n,    1);
    chk({tag, "_wr_n"},   o_wr_n,    1);
    chk({tag, "_a_d_n"},  o_a_d_n,   1);
    chk({tag, "_ad_oe"},  o_ad_oe,   0);
    chk({tag, "_ad_out"}, o_ad_out,  0);
    chk({tag, "_busy"},   o_busy,    0);
    chk({tag, "_rddata"}, o_rd_data, 0);
    chk({tag, "_done"},   o_done,    0);
  endtask

  // Called right after a negedge; start is sampled at the following posedge
  // (edge 0). Cycle k is the interval after edge k-1.
  task automatic run_read(input int t, input logic [7:0] a,
                          input logic [7:0] rv, input int e1, input int e2);
    int   nc;
    logic ea, es, er, ed, eb;
    nc      = 6 * t + 4;
    rtc_val = rv;
    addr    = a;
    start   = 1'b1;
    sb.push_back(rv);
    for (int k = 1; k <= nc; k++) begin
      @(negedge clk);
      ea = (k <= 3 * t);
      es = (k > t) && (k <= 2 * t);
      er = (k > 4 * t) && (k <= 5 * t);
      ed = (k == 6 * t + 1);
      eb = (k <= 6 * t + 1);
      chk("ad_oe", o_ad_oe, ea);
      if (ea) chk("ad_out", o_ad_out, a);
      chk("wr_n",  o_wr_n,  !es);
      chk("rd_n",  o_rd_n,  !er);
      chk("cs_n",  o_cs_n,  !(ea || er));
      chk("a_d_n", o_a_d_n, !ea);
      chk("busy",  o_busy,  eb);
      chk("done",  o_done,  ed);
      if (o_done) begin
        chk("sb_has_entry", sb.size() > 0, 1);
        if (sb.size() > 0) chk("rd_data", o_rd_data, sb.pop_front());
      end
      start = (k == e1) || (k == e2);
      if (start) addr = 8'h22;
    end
    start = 1'b0;
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    sel     = 1'b0;
    addr    = 8'h00;
    rtc_val = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("por");
    sel = 1'b1;
    #1 chk_reset_vals("por1");
    sel = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // Single read, T_PHASE=2
    run_read(2, 8'h23, 8'h45, 0, 0);
    chk("rd_data_hold", o_rd_data, 8'h45);

    // Reset mid-IDLE clears the captured byte before the next edge
    #2 reset = 1'b1;
    #1 chk_reset_vals("idle_rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Start while busy: extra requests at cycles 5 and 13 are dropped
    run_read(2, 8'h21, 8'h5C, 5, 13);

    // Reset in the middle of DATA_RD
    addr    = 8'h30;
    rtc_val = 8'h77;
    start   = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("mid_rd_n_low", o_rd_n, 0);
    #1 reset = 1'b1;
    #1 chk_reset_vals("rd_rst");
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      chk("no_done_after_abort", o_done, 0);
    end
    run_read(2, 8'h31, 8'hA6, 0, 0);

    // T_PHASE=1 boundary
    sel = 1'b1;
    @(negedge clk);
    run_read(1, 8'h00, 8'hFF, 0, 0);
    sel = 1'b0;
    @(negedge clk);

`ifdef RTC_READ_BCD_CHECK_EN
    run_read(2, 8'h10, 8'h59, 0, 0);
    chk("bcd_ok", o_bcd_err, 0);
    run_read(2, 8'h11, 8'h5A, 0, 0);
    chk("bcd_bad", o_bcd_err, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
